// File: rtl/rect_read_probe_pkg.sv
// Shared framebuffer definitions for the rectangle writer/reader pair.
// Holds the probe FSM state encoding and the framebuffer geometry defaults
// (screen size, address width, colour width, background colour).
package rect_read_probe_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int FB_SCREEN_W = 160;
  localparam int FB_SCREEN_H = 120;
  localparam int FB_ADDR_W   = 15;
  localparam int FB_COORD_W  = 10;
  localparam int FB_COLOR_W  = 3;
  localparam int FB_BG_COLOR = 0;

endpackage

// File: rtl/fb_addr_calc.sv
// Framebuffer address calculator, shared by the writer and read-probe sides.
//   x, y       in   pixel coordinates
//   addr       out  y*SCREEN_W + x, truncated to ADDR_W
//   in_screen  out  1 when x < SCREEN_W and y < SCREEN_H
module fb_addr_calc #(
  parameter int COORD_W  = 10,
  parameter int ADDR_W   = 15,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               in_screen
);

  // Arithmetic done at ADDR_W so truncation falls out of the modulo math.
  assign addr      = ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
  assign in_screen = (32'(x) < 32'(SCREEN_W)) && (32'(y) < 32'(SCREEN_H));

endmodule

// File: rtl/rect_read_probe.sv
// Rectangle read probe: scans a RECT_W x RECT_H region of the framebuffer
// through its read port and reports whether any non-background pixel exists.
//   clk, reset         clock, async active-high reset
//   go, x_in, y_in     start request and top-left corner (sampled in S_IDLE)
//   mem_addr/rden/q    framebuffer read port, 1-cycle read latency
//   busy, done         scan in progress / one-cycle results-valid pulse
//   hit, hit_count     any hit / number of non-background pixels
//   hit_color/x/y      colour and position of the first hit in raster order
module rect_read_probe
  import rect_read_probe_pkg::*;
#(
  parameter int RECT_W   = 16,
  parameter int RECT_H   = 8,
  parameter int COORD_W  = FB_COORD_W,
  parameter int COLOR_W  = FB_COLOR_W,
  parameter int SCREEN_W = FB_SCREEN_W,
  parameter int SCREEN_H = FB_SCREEN_H,
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int BG_COLOR = FB_BG_COLOR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rden,
  input  logic [COLOR_W-1:0] mem_q,
  output logic               busy,
  output logic               done,
  output logic               hit,
  output logic [15:0]        hit_count,
  output logic [COLOR_W-1:0] hit_color,
  output logic [COORD_W-1:0] hit_x,
  output logic [COORD_W-1:0] hit_y
);

  localparam int CW = (RECT_W > 1) ? $clog2(RECT_W) : 1;
  localparam int RW = (RECT_H > 1) ? $clog2(RECT_H) : 1;

  state_t state_q, state_d;

  logic [COORD_W-1:0] cur_x, cur_y, org_x;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               accept, scan, row_end, last_px;
  logic [ADDR_W-1:0]  calc_addr;
  logic               in_scr;

  // One-stage read pipeline: valid plus the coords of the pixel in flight.
  logic               vld_d;
  logic [COORD_W-1:0] px_x_d, px_y_d;
  logic               px_hit;

  assign accept  = (state_q == S_IDLE) && go;
  assign scan    = (state_q == S_SCAN);
  assign row_end = (col == CW'(RECT_W - 1));
  assign last_px = scan && row_end && (row == RW'(RECT_H - 1));

  fb_addr_calc #(
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W),
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_addr (
    .x        (cur_x),
    .y        (cur_y),
    .addr     (calc_addr),
    .in_screen(in_scr)
  );

  // Off-screen pixels are skipped by withholding the read; they never reach
  // the hit logic because their valid bit stays low.
  assign mem_rden = scan && in_scr;
  assign mem_addr = scan ? calc_addr : '0;
  assign busy     = scan || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_SCAN;
      S_SCAN:  if (last_px) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Raster scan counters: x inner, y outer. Row count wraps harmlessly after
  // the last pixel; the next accept reloads everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_x <= '0;
      cur_y <= '0;
      org_x <= '0;
      col   <= '0;
      row   <= '0;
    end else if (accept) begin
      cur_x <= x_in;
      cur_y <= y_in;
      org_x <= x_in;
      col   <= '0;
      row   <= '0;
    end else if (scan) begin
      if (row_end) begin
        col   <= '0;
        cur_x <= org_x;
        row   <= row + RW'(1);
        cur_y <= cur_y + COORD_W'(1);
      end else begin
        col   <= col + CW'(1);
        cur_x <= cur_x + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_d  <= 1'b0;
      px_x_d <= '0;
      px_y_d <= '0;
    end else begin
      vld_d  <= mem_rden;
      px_x_d <= cur_x;
      px_y_d <= cur_y;
    end
  end

  assign px_hit = vld_d && (mem_q != COLOR_W'(BG_COLOR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit       <= 1'b0;
      hit_count <= '0;
      hit_color <= '0;
      hit_x     <= '0;
      hit_y     <= '0;
    end else if (accept) begin
      hit       <= 1'b0;
      hit_count <= '0;
      hit_color <= '0;
      hit_x     <= '0;
      hit_y     <= '0;
    end else if (px_hit) begin
      hit_count <= hit_count + 16'd1;
      // Only the first hit in raster order is recorded.
      if (!hit) begin
        hit       <= 1'b1;
        hit_color <= mem_q;
        hit_x     <= px_x_d;
        hit_y     <= px_y_d;
      end
    end
  end

endmodule

// File: tb/tb_rect_read_probe.sv
module tb_rect_read_probe;

  typedef struct packed {
    logic        hit;
    logic [15:0] cnt;
    logic [2:0]  col;
    logic [9:0]  x;
    logic [9:0]  y;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [9:0]  x_in = '0, y_in = '0;
  logic [14:0] mem_addr;
  logic        mem_rden;
  logic [2:0]  mem_q = '0;
  logic        busy, done, hit;
  logic [15:0] hit_count;
  logic [2:0]  hit_color;
  logic [9:0]  hit_x, hit_y;

  logic [2:0]  ram [0:32767];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, rd_cnt = 0, done_cnt = 0;
  logic prev_done = 1'b0;

  logic [14:0] exp_addr_q[$];
  res_t        exp_res_q[$];
  int          done_cyc_q[$];

  rect_read_probe #(.RECT_W(4), .RECT_H(2)) dut (
    .clk(clk), .reset(reset), .go(go), .x_in(x_in), .y_in(y_in),
    .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_q(mem_q),
    .busy(busy), .done(done), .hit(hit), .hit_count(hit_count),
    .hit_color(hit_color), .hit_x(hit_x), .hit_y(hit_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rden) mem_q <= ram[mem_addr];
  end

  // Read-address and result scoreboard.
  always @(negedge clk) begin
    if (mem_rden) begin
      logic [14:0] ea;
      rd_cnt++;
      n_tests++;
      if (exp_addr_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_addr unexpected read got=%0d required=none", mem_addr);
      end else begin
        ea = exp_addr_q.pop_front();
        if (mem_addr !== ea) begin
          n_fail++;
          $display("FAIL rd_addr got=%0d required=%0d", mem_addr, ea);
        end
      end
    end
    if (done) begin
      res_t got, er;
      done_cnt++;
      done_cyc_q.push_back(cyc);
      n_tests++;
      if (prev_done) begin
        n_fail++;
        $display("FAIL done_width got=2+ cycles required=1");
      end
      got = '{hit, hit_count, hit_color, hit_x, hit_y};
      n_tests++;
      if (exp_res_q.size() == 0) begin
        n_fail++;
        $display("FAIL result unexpected done required=no done");
      end else begin
        er = exp_res_q.pop_front();
        if (got !== er) begin
          n_fail++;
          $display("FAIL result got hit=%0d cnt=%0d col=%0d x=%0d y=%0d required hit=%0d cnt=%0d col=%0d x=%0d y=%0d",
                   got.hit, got.cnt, got.col, got.x, got.y, er.hit, er.cnt, er.col, er.x, er.y);
        end
      end
    end
    prev_done = done;
  end

  // Reference model: expected reads and result of a 4x2 scan at (x0,y0).
  task automatic model(input logic [9:0] x0, input logic [9:0] y0);
    res_t r = '0;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++) begin
        int px = int'(x0) + i;
        int py = int'(y0) + j;
        if (px < 160 && py < 120) begin
          int a = py * 160 + px;
          exp_addr_q.push_back(15'(a));
          if (ram[a] != 3'd0) begin
            if (!r.hit) begin
              r.hit = 1'b1;
              r.col = ram[a];
              r.x   = 10'(px);
              r.y   = 10'(py);
            end
            r.cnt = r.cnt + 16'd1;
          end
        end
      end
    exp_res_q.push_back(r);
  endtask

  task automatic pulse_go(input logic [9:0] x, input logic [9:0] y, output int go_c);
    @(posedge clk); #1;
    x_in = x; y_in = y; go = 1'b1; go_c = cyc;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_dones(input int base, input int n, input string nm);
    for (int k = 0; k < 80; k++) begin
      if (done_cnt >= base + n) break;
      @(posedge clk);
    end
    n_tests++;
    if (done_cnt < base + n) begin
      n_fail++;
      $display("FAIL %s timeout dones got=%0d required=%0d", nm, done_cnt - base, n);
    end
  endtask

  task automatic check_lat(input int exp_c, input string nm);
    int c;
    n_tests++;
    if (done_cyc_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s no done cycle recorded required=%0d", nm, exp_c);
    end else begin
      c = done_cyc_q.pop_front();
      if (c !== exp_c) begin
        n_fail++;
        $display("FAIL %s done cycle got=%0d required=%0d", nm, c, exp_c);
      end
    end
  endtask

  task automatic check_zero(input string nm);
    logic [64:0] v;
    v = {busy, done, hit, hit_count, hit_color, hit_x, hit_y, mem_rden, mem_addr};
    n_tests++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL %s outputs got=%h required=0", nm, v);
    end
  endtask

  task automatic run_scan(input logic [9:0] x, input logic [9:0] y, input int exp_rd, input string nm);
    int go_c, base, rd0;
    base = done_cnt; rd0 = rd_cnt;
    model(x, y);
    pulse_go(x, y, go_c);
    wait_dones(base, 1, nm);
    check_lat(go_c + 10, nm);
    n_tests++;
    if (rd_cnt - rd0 !== exp_rd) begin
      n_fail++;
      $display("FAIL %s reads got=%0d required=%0d", nm, rd_cnt - rd0, exp_rd);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("reset_held");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset_released");
  endtask

  task automatic test_all_bg();
    run_scan(10'd10, 10'd20, 8, "all_bg");
    @(posedge clk); #1;
    n_tests++;
    if ({hit, hit_count} !== 17'd0 || mem_rden !== 1'b0 || mem_addr !== 15'd0) begin
      n_fail++;
      $display("FAIL all_bg idle got hit=%0d cnt=%0d rden=%0d addr=%0d required 0", hit, hit_count, mem_rden, mem_addr);
    end
  endtask

  task automatic test_two_hits();
    ram[3372] = 3'b101;
    ram[3211] = 3'b011;
    run_scan(10'd10, 10'd20, 8, "two_hits");
    repeat (5) @(posedge clk);
    #1 n_tests++;
    if (hit !== 1'b1 || hit_count !== 16'd2 || hit_color !== 3'b011 || hit_x !== 10'd11 || hit_y !== 10'd20) begin
      n_fail++;
      $display("FAIL two_hits held got hit=%0d cnt=%0d col=%0d x=%0d y=%0d required 1 2 3 11 20",
               hit, hit_count, hit_color, hit_x, hit_y);
    end
  endtask

  task automatic test_edge();
    ram[19199] = 3'b010;
    run_scan(10'd158, 10'd119, 2, "edge");
    #1 n_tests++;
    if (hit_x !== 10'd159 || hit_y !== 10'd119 || hit_count !== 16'd1) begin
      n_fail++;
      $display("FAIL edge got x=%0d y=%0d cnt=%0d required 159 119 1", hit_x, hit_y, hit_count);
    end
  endtask

  task automatic test_go_ignored();
    int go_c, base;
    base = done_cnt;
    model(10'd10, 10'd20);
    pulse_go(10'd10, 10'd20, go_c);
    @(posedge clk); #1;
    x_in = 10'd50; y_in = 10'd60; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    wait_dones(base, 1, "go_ignored");
    check_lat(go_c + 10, "go_ignored");
    repeat (15) @(posedge clk);
    #1 n_tests++;
    if (done_cnt !== base + 1 || hit_x !== 10'd11) begin
      n_fail++;
      $display("FAIL go_ignored got dones=%0d x=%0d required 1 11", done_cnt - base, hit_x);
    end
  endtask

  task automatic test_reset_mid();
    int go_c, base;
    base = done_cnt;
    model(10'd10, 10'd20);
    pulse_go(10'd10, 10'd20, go_c);
    while (cyc < go_c + 5) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_zero("reset_mid");
    exp_addr_q.delete();
    exp_res_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1 n_tests++;
    if (done_cnt !== base) begin
      n_fail++;
      $display("FAIL reset_mid dones got=%0d required=0", done_cnt - base);
    end
    run_scan(10'd10, 10'd20, 8, "after_reset");
  endtask

  task automatic test_back_to_back();
    int go_c, base;
    ram[40*160+31] = 3'b110;
    base = done_cnt;
    for (int s = 0; s < 3; s++) model(10'd30, 10'd40);
    @(posedge clk); #1;
    x_in = 10'd30; y_in = 10'd40; go = 1'b1; go_c = cyc;
    repeat (30) @(posedge clk);
    #1 go = 1'b0;
    wait_dones(base, 3, "b2b");
    check_lat(go_c + 10, "b2b_1");
    check_lat(go_c + 21, "b2b_2");
    check_lat(go_c + 32, "b2b_3");
    repeat (15) @(posedge clk);
    #1 n_tests++;
    if (done_cnt !== base + 3) begin
      n_fail++;
      $display("FAIL b2b extra dones got=%0d required=3", done_cnt - base);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 3'd0;
    test_reset();
    test_all_bg();
    test_two_hits();
    test_edge();
    test_go_ignored();
    test_reset_mid();
    test_back_to_back();
    n_tests++;
    if (exp_addr_q.size() != 0 || exp_res_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftovers got addr=%0d res=%0d required 0 0", exp_addr_q.size(), exp_res_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
